// File: rtl/wr_dec_multiport.sv
// Registered multi-port write-enable decoder for the register file.
// Per-port one-hot row enables with zero-row masking and highest-port-wins collision resolution.
`timescale 1ns/1ps
module wr_dec_multiport #(
  parameter int          ADDR_W   = 5,
  parameter int          PORTS    = 2,
  parameter int          ZERO_EN  = 1,
  parameter int unsigned ZERO_ROW = 31,
  parameter int          CNT_W    = 8,
  localparam int         ROWS     = 2**ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [PORTS-1:0]      wr_en,
  input  logic [PORTS*ADDR_W-1:0] wr_addr,
  input  logic                  clr_cnt,
  output logic [PORTS*ROWS-1:0] out,
  output logic [ROWS-1:0]       merged,
  output logic [PORTS-1:0]      any_wr,
  output logic                  conflict,
  output logic [CNT_W-1:0]      conflict_cnt
);

  logic [ROWS-1:0]       raw [PORTS];
  logic [ROWS-1:0]       res [PORTS];
  logic [ROWS-1:0]       claimed;
  logic                  hit;

  logic [PORTS*ROWS-1:0] out_d, out_q;
  logic [ROWS-1:0]       merged_d, merged_q;
  logic [PORTS-1:0]      any_wr_d, any_wr_q;
  logic                  conflict_d, conflict_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q;

  // Walk ports from highest to lowest; rows already claimed by a higher port are lost.
  always_comb begin
    claimed = '0;
    hit     = 1'b0;
    for (int p = PORTS - 1; p >= 0; p--) begin
      raw[p] = '0;
      if (wr_en[p] &&
          !((ZERO_EN != 0) && (32'(wr_addr[p*ADDR_W +: ADDR_W]) == ZERO_ROW))) begin
        raw[p][wr_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
      end
      res[p] = raw[p] & ~claimed;
      if ((raw[p] & claimed) != '0) begin
        hit = 1'b1;
      end
      claimed = claimed | raw[p];
    end
  end

  always_comb begin
    out_d      = out_q;
    merged_d   = merged_q;
    any_wr_d   = any_wr_q;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;
    if (!stall) begin
      merged_d = '0;
      for (int p = 0; p < PORTS; p++) begin
        out_d[p*ROWS +: ROWS] = res[p];
        any_wr_d[p]           = |res[p];
        merged_d              = merged_d | res[p];
      end
      conflict_d = hit;
      if (hit && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Clear wins over increment and is honoured while stalled.
    if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q      <= '0;
      merged_q   <= '0;
      any_wr_q   <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      merged_q   <= merged_d;
      any_wr_q   <= any_wr_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out          = out_q;
  assign merged       = merged_q;
  assign any_wr       = any_wr_q;
  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/wr_dec_multiport.md
Name: wr_dec_multiport

Overview:
- Parametrised, registered write-enable decoder for the register file; successor to the flat 5-to-32 enable decoder.
- Decodes PORTS independent write addresses into one-hot row enables, one output vector per port.
- Masks the hardwired zero register.
- Resolves same-row collisions between ports by fixed priority and counts them.
- Outputs are registered (one pipeline stage) with stall-hold, so it sits at the writeback stage boundary.

Parameters:
- ADDR_W, 5, address width; ROWS = 2**ADDR_W rows.
- PORTS, 2, number of write ports (1..4).
- ZERO_EN, 1, when 1, writes to row ZERO_ROW are suppressed.
- ZERO_ROW, 31, index of the hardwired zero register.
- CNT_W, 8, width of the saturating collision counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- stall  input  1  when 1, all registered outputs and the counter hold.
- wr_en  input  PORTS  per-port write request.
- wr_addr  input  PORTS*ADDR_W  packed addresses; port p at [p*ADDR_W +: ADDR_W].
- clr_cnt  input  1  synchronous clear of conflict_cnt.
- out  output  PORTS*ROWS  registered one-hot enables; port p at [p*ROWS +: ROWS].
- merged  output  ROWS  registered OR of all per-port vectors.
- any_wr  output  PORTS  registered; 1 if port p's vector is nonzero.
- conflict  output  1  registered; 1 if a collision was resolved this cycle.
- conflict_cnt  output  CNT_W  saturating count of collision cycles.

Behaviour:
- Reset (asynchronous, active-high): out, merged, any_wr, conflict, conflict_cnt all 0, whether the reset asserts mid-stall or mid-burst. After reset deasserts, the first edge with stall=0 loads new values.
- Latency: inputs sampled at edge k appear on the outputs after edge k; exactly 1 cycle.
- Raw decode, per port p:
  - raw_p = (1 << wr_addr_p) when wr_en[p]=1, else 0.
  - If ZERO_EN=1 and wr_addr_p == ZERO_ROW, raw_p = 0.
  - A masked zero-row write is not a collision.
- Collision resolution:
  - A row set in raw vectors of two or more ports is a collision.
  - The highest-index port keeps the row; the bit is cleared in every lower-index port's vector.
  - Example: ports 0, 1 and 2 all hit row 7; only port 2 keeps bit 7.
- Registered outputs:
  - The resolved vector of port p loads into out[p].
  - merged = OR of resolved vectors; any_wr[p] = |resolved_p.
  - conflict = 1 when any row collided; a port whose only row lost shows any_wr=0.
- Counter:
  - On an unstalled edge with a collision, conflict_cnt increments by 1, saturating at 2**CNT_W-1 with no wrap.
  - clr_cnt=1 sets the counter to 0 at the edge, overriding any increment; clr_cnt acts even when stall=1.
- Stall: when stall=1, out, merged, any_wr, conflict and conflict_cnt hold their previous values; inputs are ignored except clr_cnt.
- Invariants after every edge:
  - Each out[p] is one-hot or zero.
  - No row is set in two ports.
  - popcount(merged) equals the number of ports with any_wr set.

Test Plan:
1. Reset, then PORTS=2, wr_en=2'b01, wr_addr0=5 -> after 1 edge out[0]=32'h0000_0020, out[1]=0, merged=32'h20, any_wr=2'b01, conflict=0.
2. wr_en=2'b11, addr0=3, addr1=3 -> out[0]=0, out[1]=32'h8, any_wr=2'b10, conflict=1, conflict_cnt=1; repeat 300 cycles with CNT_W=8 -> conflict_cnt stays 255.
3. ZERO_EN=1, wr_en=2'b11, addr0=31, addr1=31 -> out=0, merged=0, any_wr=0, conflict=0, counter unchanged.
4. Load addr0=4, then stall=1 while inputs change to addr0=9 for 3 cycles -> out[0] holds 32'h10; release stall -> next edge out[0]=32'h200.
5. conflict_cnt=10 with stall=1, clr_cnt=1 -> counter 0 at the edge; clr_cnt=1 together with a collision -> counter 0.
6. Assert reset asynchronously mid-cycle with out nonzero and conflict_cnt=5 -> all outputs 0 before the next clock edge; ADDR_W=3, PORTS=3 variant: all ports addr 6 -> only out[2]=8'h40.
